pe_result_to_blockfp: RTL and testbench

Converts the float results produced by the PE accumulators back into block floating point, so one layer's outputs can be fed to the next layer as features. It collects a block of `BLOCK_SIZE` float results and finds their maximum exponent, which becomes the shared block exponent. It then emits each element as a signed `FEATURE_WIDTH` mantissa aligned to that exponent. It sits between the PE array result drain and the feature buffer write port.

---
 rtl/pe_types.sv | 32 +++
 rtl/pe_blockfp_align.sv | 50 +++++
 rtl/pe_result_to_blockfp.sv | 145 ++++++++++++++
 tb/tb_pe_result_to_blockfp.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_types.sv
// Shared types for the PE datapath: configuration record and the
// state encoding of the float-to-block-floating-point converter.
package pe_types;

  typedef struct packed {
    int RESULT_WIDTH;
    int RESULT_EXPONENT_WIDTH;
    int RESULT_MANTISSA_WIDTH;
    int RESULT_EXPONENT_BIAS;
    int FEATURE_WIDTH;
    int EXPONENT_WIDTH;
    int EXPONENT_BIAS;
  } pe_cfg_t;

  // fp16 results folded into 8-bit features with a 5-bit shared exponent
  localparam pe_cfg_t PE_CFG_DEFAULT = '{
    RESULT_WIDTH:          16,
    RESULT_EXPONENT_WIDTH: 5,
    RESULT_MANTISSA_WIDTH: 10,
    RESULT_EXPONENT_BIAS:  15,
    FEATURE_WIDTH:         8,
    EXPONENT_WIDTH:        5,
    EXPONENT_BIAS:         15
  };

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ALIGN   = 2'd1,
    EMIT    = 2'd2
  } blockfp_conv_state_e;

endpackage

// File: rtl/pe_blockfp_align.sv
// Aligns one float result to the block exponent and returns it as a
// signed fixed-point feature mantissa (combinational).
module pe_blockfp_align
  import pe_types::*;
#(
  parameter pe_cfg_t cfg = PE_CFG_DEFAULT
) (
  input  logic [cfg.RESULT_WIDTH-1:0]          i_float,
  input  logic [cfg.RESULT_EXPONENT_WIDTH-1:0] i_emax,
  input  logic [cfg.RESULT_EXPONENT_WIDTH+1:0] i_xshift,
  input  logic                                 i_sat,
  output logic signed [cfg.FEATURE_WIDTH-1:0]  o_mantissa
);

  localparam int REW    = cfg.RESULT_EXPONENT_WIDTH;
  localparam int RMW    = cfg.RESULT_MANTISSA_WIDTH;
  localparam int FW     = cfg.FEATURE_WIDTH;
  localparam int PRE_SH = RMW - (FW - 2);

  localparam logic [REW+2:0] SHIFT_LIMIT = (REW+3)'(FW - 1);
  localparam logic [FW-2:0]  MAG_MAX     = '1;

  typedef struct packed {
    logic           sign;
    logic [REW-1:0] exp;
    logic [RMW-1:0] man;
  } float_fields_t;

  float_fields_t  w_f;
  logic [RMW:0]   w_full;
  logic [REW+2:0] w_shift;
  logic [FW-2:0]  w_mag;

  assign w_f     = i_float;
  assign w_full  = {1'b1, w_f.man};
  assign w_shift = {3'b000, i_emax} - {3'b000, w_f.exp} + {1'b0, i_xshift};

  // Shifts past the fraction width leave nothing but zero behind
  always_comb begin
    w_mag = '0;
    if (w_f.exp == '0)
      w_mag = '0;
    else if (i_sat)
      w_mag = MAG_MAX;
    else if (w_shift < SHIFT_LIMIT)
      w_mag = (FW-1)'((w_full >> PRE_SH) >> w_shift);
    o_mantissa = w_f.sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  end

endmodule

// File: rtl/pe_result_to_blockfp.sv
// Collects a block of float PE results, picks the largest exponent as the
// shared block exponent and streams out aligned signed feature mantissas.
module pe_result_to_blockfp
  import pe_types::*;
#(
  parameter pe_cfg_t cfg        = PE_CFG_DEFAULT,
  parameter int      BLOCK_SIZE = 8
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            i_valid,
  input  logic [cfg.RESULT_WIDTH-1:0]     i_result,
  output logic                            o_ready,
  output logic                            o_valid,
  output logic [cfg.FEATURE_WIDTH-1:0]    o_mantissa,
  output logic [cfg.EXPONENT_WIDTH-1:0]   o_exp,
  output logic                            o_last,
  input  logic                            i_ready
);

  localparam int RW  = cfg.RESULT_WIDTH;
  localparam int REW = cfg.RESULT_EXPONENT_WIDTH;
  localparam int RMW = cfg.RESULT_MANTISSA_WIDTH;
  localparam int FW  = cfg.FEATURE_WIDTH;
  localparam int EW  = cfg.EXPONENT_WIDTH;
  localparam int EBW = REW + 2;
  localparam int IW  = $clog2(BLOCK_SIZE);

  localparam logic [IW-1:0]         IDX_LAST   = IW'(BLOCK_SIZE - 1);
  localparam logic signed [EBW-1:0] BIAS_DELTA = EBW'(cfg.EXPONENT_BIAS - cfg.RESULT_EXPONENT_BIAS);
  localparam logic signed [EBW-1:0] EXP_MAX    = EBW'((1 << EW) - 1);

  if (RMW < FW - 2) begin : g_chk_mant
    $fatal(1, "RESULT_MANTISSA_WIDTH too narrow for FEATURE_WIDTH");
  end
  if (BLOCK_SIZE < 2) begin : g_chk_block
    $fatal(1, "BLOCK_SIZE must be at least 2");
  end
  if (RW != 1 + REW + RMW) begin : g_chk_fields
    $fatal(1, "RESULT_WIDTH does not match sign+exponent+mantissa");
  end

  blockfp_conv_state_e   r_state;
  logic [IW-1:0]         r_wr_idx;
  logic [IW-1:0]         r_rd_idx;
  logic [REW-1:0]        r_emax;
  logic [EBW-1:0]        r_xshift;
  logic                  r_sat;
  logic [EW-1:0]         r_exp;
  logic                  r_o_ready;
  logic                  r_o_valid;
  logic [RW-1:0]         r_buf [BLOCK_SIZE];

  logic [REW-1:0]        w_in_exp;
  logic                  w_accept;
  logic signed [EBW-1:0] w_eb;
  logic signed [FW-1:0]  w_mantissa;

  assign w_in_exp = i_result[RW-2 -: REW];
  assign w_accept = i_valid && r_o_ready && (r_state == COLLECT);
  assign w_eb     = $signed({2'b00, r_emax}) + BIAS_DELTA;

  always_ff @(posedge clock) begin
    if (w_accept) r_buf[r_wr_idx] <= i_result;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= COLLECT;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_emax    <= '0;
      r_xshift  <= '0;
      r_sat     <= 1'b0;
      r_exp     <= '0;
      r_o_ready <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_o_ready <= 1'b1;
          if (w_accept) begin
            r_wr_idx <= r_wr_idx + IW'(1);
            if (w_in_exp > r_emax) r_emax <= w_in_exp;
            if (r_wr_idx == IDX_LAST) begin
              r_state   <= ALIGN;
              r_o_ready <= 1'b0;
            end
          end
        end
        ALIGN: begin
          r_state   <= EMIT;
          r_o_valid <= 1'b1;
          r_sat     <= 1'b0;
          r_xshift  <= '0;
          // A negative block exponent is absorbed as extra right shift
          if (r_emax == '0) begin
            r_exp <= '0;
          end else if (w_eb[EBW-1]) begin
            r_exp    <= '0;
            r_xshift <= -w_eb;
          end else if (w_eb > EXP_MAX) begin
            r_exp <= '1;
            r_sat <= 1'b1;
          end else begin
            r_exp <= EW'(w_eb);
          end
        end
        EMIT: begin
          if (i_ready) begin
            if (r_rd_idx == IDX_LAST) begin
              r_state   <= COLLECT;
              r_o_valid <= 1'b0;
              r_o_ready <= 1'b1;
              r_wr_idx  <= '0;
              r_rd_idx  <= '0;
              r_emax    <= '0;
              r_sat     <= 1'b0;
            end else begin
              r_rd_idx <= r_rd_idx + IW'(1);
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  pe_blockfp_align #(
    .cfg(cfg)
  ) u_align (
    .i_float    (r_buf[r_rd_idx]),
    .i_emax     (r_emax),
    .i_xshift   (r_xshift),
    .i_sat      (r_sat),
    .o_mantissa (w_mantissa)
  );

  assign o_ready    = r_o_ready;
  assign o_valid    = r_o_valid;
  assign o_mantissa = w_mantissa;
  assign o_exp      = r_exp;
  assign o_last     = r_o_valid && (r_rd_idx == IDX_LAST);

endmodule

// File: tb/tb_pe_result_to_blockfp.sv
// Bench for pe_result_to_blockfp: three instances differing only in the
// shared-exponent bias, checked against a real-valued reference model.
module tb_pe_result_to_blockfp;
  import pe_types::*;

  localparam int BS = 4;
  localparam pe_cfg_t CFG0 = '{RESULT_WIDTH: 16, RESULT_EXPONENT_WIDTH: 5, RESULT_MANTISSA_WIDTH: 10,
                               RESULT_EXPONENT_BIAS: 15, FEATURE_WIDTH: 8, EXPONENT_WIDTH: 5, EXPONENT_BIAS: 15};
  localparam pe_cfg_t CFG1 = '{RESULT_WIDTH: 16, RESULT_EXPONENT_WIDTH: 5, RESULT_MANTISSA_WIDTH: 10,
                               RESULT_EXPONENT_BIAS: 15, FEATURE_WIDTH: 8, EXPONENT_WIDTH: 5, EXPONENT_BIAS: 7};
  localparam pe_cfg_t CFG2 = '{RESULT_WIDTH: 16, RESULT_EXPONENT_WIDTH: 5, RESULT_MANTISSA_WIDTH: 10,
                               RESULT_EXPONENT_BIAS: 15, FEATURE_WIDTH: 8, EXPONENT_WIDTH: 5, EXPONENT_BIAS: 20};

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  iv = '0;
  logic [2:0]  ir = '0;
  logic [2:0]  ordy;
  logic [2:0]  ov;
  logic [2:0]  olast;
  logic [15:0] res [3];
  logic [7:0]  om  [3];
  logic [4:0]  oe  [3];

  int checks = 0;
  int failures = 0;

  logic [15:0] blk [4];
  int          mdl_m [4];
  int          mdl_e;
  int          cap_m [4];
  int          cap_e [4];
  logic        cap_l [4];

  always #5 clock = ~clock;

  pe_result_to_blockfp #(.cfg(CFG0), .BLOCK_SIZE(BS)) u_dut0 (
    .clock(clock), .resetn(resetn), .i_valid(iv[0]), .i_result(res[0]), .o_ready(ordy[0]),
    .o_valid(ov[0]), .o_mantissa(om[0]), .o_exp(oe[0]), .o_last(olast[0]), .i_ready(ir[0]));
  pe_result_to_blockfp #(.cfg(CFG1), .BLOCK_SIZE(BS)) u_dut1 (
    .clock(clock), .resetn(resetn), .i_valid(iv[1]), .i_result(res[1]), .o_ready(ordy[1]),
    .o_valid(ov[1]), .o_mantissa(om[1]), .o_exp(oe[1]), .o_last(olast[1]), .i_ready(ir[1]));
  pe_result_to_blockfp #(.cfg(CFG2), .BLOCK_SIZE(BS)) u_dut2 (
    .clock(clock), .resetn(resetn), .i_valid(iv[2]), .i_result(res[2]), .o_ready(ordy[2]),
    .o_valid(ov[2]), .o_mantissa(om[2]), .o_exp(oe[2]), .o_last(olast[2]), .i_ready(ir[2]));

  function automatic real pow2(input int n);
    real r = 1.0;
    for (int i = 0; i < n; i++) r = r * 2.0;
    for (int i = 0; i > n; i--) r = r / 2.0;
    return r;
  endfunction

  // Numeric value of an fp16 word; exponent 0 is zero
  function automatic real fval(input logic [15:0] h);
    int e;
    real v;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    v = (1.0 + real'(int'(h[9:0])) / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  // Block exponent = largest element exponent rebiased; mantissas carry 6 fraction bits
  task automatic model(input int ebias);
    int emax;
    int eb;
    real scale;
    emax = 0;
    for (int i = 0; i < 4; i++)
      if (int'(blk[i][14:10]) > emax) emax = int'(blk[i][14:10]);
    if (emax == 0) begin
      mdl_e = 0;
      for (int i = 0; i < 4; i++) mdl_m[i] = 0;
    end else begin
      eb = emax - 15 + ebias;
      if (eb > 31) begin
        mdl_e = 31;
        for (int i = 0; i < 4; i++)
          mdl_m[i] = (blk[i][14:10] == 5'd0) ? 0 : (blk[i][15] ? -127 : 127);
      end else begin
        mdl_e = (eb < 0) ? 0 : eb;
        scale = pow2(mdl_e - ebias - 6);
        for (int i = 0; i < 4; i++) mdl_m[i] = $rtoi(fval(blk[i]) / scale);
      end
    end
  endtask

  task automatic rand_block(input int base);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] h;
      int e;
      h = 16'($urandom);
      e = base - int'($urandom_range(0, 9));
      if (e < 1 || $urandom_range(0, 5) == 0) e = 0;
      h[14:10] = 5'(e);
      blk[i] = h;
    end
  endtask

  task automatic send_elem(input int k, input logic [15:0] d, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    iv[k] = 1'b1;
    res[k] = d;
    while (n < 60 && !ok) begin
      @(negedge clock);
      if (ordy[k]) ok = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    iv[k] = 1'b0;
  endtask

  task automatic send_block(input int k, output bit ok);
    bit e_ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_elem(k, blk[i], e_ok);
      ok = ok && e_ok;
    end
  endtask

  task automatic drain(input int k, input int first, input int n, output bit ok);
    int idx;
    int cyc;
    idx = first;
    cyc = 0;
    ir[k] = 1'b1;
    while (idx < first + n && cyc < 100) begin
      @(negedge clock);
      if (ov[k]) begin
        cap_m[idx] = int'($signed(om[k]));
        cap_e[idx] = int'(oe[k]);
        cap_l[idx] = olast[k];
        idx++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    ir[k] = 1'b0;
    ok = (idx == first + n);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || ordy[k] !== 1'b0 || olast[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags dut%0d: got v=%b r=%b l=%b expected 0 0 0", k, ov[k], ordy[k], olast[k]);
      end
      checks++;
      if (oe[k] !== 5'd0) begin
        failures++;
        $display("FAIL reset_exp dut%0d: got %0d expected 0", k, oe[k]);
      end
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (ordy !== 3'b000) begin
      failures++;
      $display("FAIL ready_before_edge: got %b expected 000", ordy);
    end
    @(posedge clock); #1;
    checks++;
    if (ordy !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_edge: got %b expected 111", ordy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] tin [3][4];
    int          tm  [3][4];
    int          te  [3];
    bit          ok;
    tin = '{'{16'h3C00, 16'h3800, 16'hBC00, 16'h0000},
            '{16'h3E00, 16'h1C00, 16'h0000, 16'hBA00},
            '{16'h0000, 16'h8000, 16'h0000, 16'h0000}};
    tm  = '{'{64, 32, -64, 0}, '{96, 0, 0, -48}, '{0, 0, 0, 0}};
    te  = '{15, 15, 0};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) blk[i] = tin[b][i];
      send_block(0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_accept blk%0d: got timeout expected accept", b); end
      checks++;
      if (ov[0] !== 1'b0) begin failures++; $display("FAIL basic_align_cycle blk%0d: got valid=%b expected 0", b, ov[0]); end
      @(posedge clock); #1;
      checks++;
      if (ov[0] !== 1'b1) begin failures++; $display("FAIL basic_latency blk%0d: got valid=%b expected 1", b, ov[0]); end
      drain(0, 0, 4, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_drain blk%0d: got timeout expected 4 outputs", b); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_m[i] !== tm[b][i]) begin failures++; $display("FAIL basic_mant blk%0d[%0d]: got %0d expected %0d", b, i, cap_m[i], tm[b][i]); end
        checks++;
        if (cap_e[i] !== te[b]) begin failures++; $display("FAIL basic_exp blk%0d[%0d]: got %0d expected %0d", b, i, cap_e[i], te[b]); end
        checks++;
        if (cap_l[i] !== (i == 3)) begin failures++; $display("FAIL basic_last blk%0d[%0d]: got %b expected %b", b, i, cap_l[i], i == 3); end
      end
    end
  endtask

  // Fixed vector followed by random blocks on instance k with its own bias
  task automatic test_bias_case(input int k, input int ebias, input logic [15:0] fixed [4],
                                input int fixed_m [4], input int fixed_e);
    bit ok;
    for (int b = 0; b < 5; b++) begin
      if (b == 0) begin
        for (int i = 0; i < 4; i++) begin blk[i] = fixed[i]; mdl_m[i] = fixed_m[i]; end
        mdl_e = fixed_e;
      end else begin
        rand_block(int'($urandom_range(1, 30)));
        model(ebias);
      end
      send_block(k, ok);
      drain(k, 0, 4, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bias%0d_drain blk%0d: got timeout expected 4 outputs", ebias, b); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_m[i] !== mdl_m[i]) begin
          failures++;
          $display("FAIL bias%0d_mant blk%0d[%0d] in=%h: got %0d expected %0d", ebias, b, i, blk[i], cap_m[i], mdl_m[i]);
        end
        checks++;
        if (cap_e[i] !== mdl_e) begin failures++; $display("FAIL bias%0d_exp blk%0d[%0d]: got %0d expected %0d", ebias, b, i, cap_e[i], mdl_e); end
      end
    end
  endtask

  task automatic test_underflow();
    logic [15:0] f [4];
    int          m [4];
    f = '{16'h1400, 16'h1400, 16'h1400, 16'h1400};
    m = '{8, 8, 8, 8};
    test_bias_case(1, 7, f, m, 0);
  endtask

  task automatic test_saturate();
    logic [15:0] f [4];
    int          m [4];
    f = '{16'h7800, 16'h3C00, 16'hBC00, 16'h0000};
    m = '{127, 127, -127, 0};
    test_bias_case(2, 20, f, m, 31);
  endtask

  task automatic test_random();
    bit ok;
    for (int b = 0; b < 6; b++) begin
      rand_block(int'($urandom_range(1, 30)));
      model(15);
      send_block(0, ok);
      drain(0, 0, 4, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL random_drain blk%0d: got timeout expected 4 outputs", b); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_m[i] !== mdl_m[i] || cap_e[i] !== mdl_e) begin
          failures++;
          $display("FAIL random_elem blk%0d[%0d] in=%h: got m=%0d e=%0d expected m=%0d e=%0d",
                   b, i, blk[i], cap_m[i], cap_e[i], mdl_m[i], mdl_e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          acc_t [$];
    int          out_t [$];
    int          gm [$];
    int          ge [$];
    logic        gl [$];
    logic [15:0] din [8];
    int          na;
    bit          acc;
    for (int h = 0; h < 2; h++) begin
      rand_block(int'($urandom_range(1, 30)));
      for (int i = 0; i < 4; i++) din[h*4+i] = blk[i];
    end
    na = 0;
    ir[0] = 1'b1;
    iv[0] = 1'b1;
    res[0] = din[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      acc = iv[0] && ordy[0];
      if (ov[0]) begin
        out_t.push_back(c);
        gm.push_back(int'($signed(om[0])));
        ge.push_back(int'(oe[0]));
        gl.push_back(olast[0]);
      end
      if (acc) begin acc_t.push_back(c); na++; end
      @(posedge clock); #1;
      if (acc) begin
        if (na < 8) res[0] = din[na];
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    ir[0] = 1'b0;
    checks++;
    if (acc_t.size() != 8 || out_t.size() != 8) begin
      failures++;
      $display("FAIL b2b_counts: got acc=%0d out=%0d expected 8 8", acc_t.size(), out_t.size());
    end else begin
      checks++;
      if (acc_t[4] - acc_t[0] != 9) begin failures++; $display("FAIL b2b_period: got %0d expected 9", acc_t[4] - acc_t[0]); end
      checks++;
      if (out_t[0] - acc_t[3] != 2) begin failures++; $display("FAIL b2b_latency: got %0d expected 2", out_t[0] - acc_t[3]); end
      checks++;
      if (out_t[3] - out_t[0] != 3) begin failures++; $display("FAIL b2b_emit_rate: got %0d expected 3", out_t[3] - out_t[0]); end
      for (int h = 0; h < 2; h++) begin
        for (int i = 0; i < 4; i++) blk[i] = din[h*4+i];
        model(15);
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (gm[h*4+i] !== mdl_m[i] || ge[h*4+i] !== mdl_e || gl[h*4+i] !== (i == 3)) begin
            failures++;
            $display("FAIL b2b_elem %0d: got m=%0d e=%0d l=%b expected m=%0d e=%0d l=%b",
                     h*4+i, gm[h*4+i], ge[h*4+i], gl[h*4+i], mdl_m[i], mdl_e, i == 3);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    blk = '{16'h3E00, 16'h3800, 16'hBA00, 16'h3C00};
    model(15);
    send_block(0, ok);
    drain(0, 0, 1, ok);
    for (int c = 0; c < 3; c++) begin
      iv[0] = (c != 1);
      res[0] = 16'h7BFF;
      @(negedge clock);
      checks++;
      if (int'($signed(om[0])) !== mdl_m[1] || int'(oe[0]) !== mdl_e || olast[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold c%0d: got m=%0d e=%0d l=%b expected m=%0d e=%0d l=0",
                 c, $signed(om[0]), oe[0], olast[0], mdl_m[1], mdl_e);
      end
      checks++;
      if (ordy[0] !== 1'b0 || ov[0] !== 1'b1) begin
        failures++;
        $display("FAIL stall_flags c%0d: got ready=%b valid=%b expected 0 1", c, ordy[0], ov[0]);
      end
      @(posedge clock); #1;
    end
    iv[0] = 1'b0;
    drain(0, 1, 3, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_m[i] !== mdl_m[i] || cap_l[i] !== (i == 3)) begin
        failures++;
        $display("FAIL stall_elem[%0d]: got m=%0d l=%b expected m=%0d l=%b", i, cap_m[i], cap_l[i], mdl_m[i], i == 3);
      end
    end
    rand_block(20);
    model(15);
    send_block(0, ok);
    drain(0, 0, 4, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_m[i] !== mdl_m[i] || cap_e[i] !== mdl_e) begin
        failures++;
        $display("FAIL stall_next_blk[%0d]: got m=%0d e=%0d expected m=%0d e=%0d", i, cap_m[i], cap_e[i], mdl_m[i], mdl_e);
      end
    end
  endtask

  task automatic test_reset_midblock();
    bit ok;
    bit seen_valid;
    send_elem(0, 16'h7800, ok);
    send_elem(0, 16'h7400, ok);
    resetn = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || ordy[0] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: got valid=%b ready=%b expected 0 0", ov[0], ordy[0]);
    end
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    blk = '{16'h3C00, 16'hB800, 16'h3400, 16'h3A00};
    model(15);
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_elem(0, blk[i], ok);
      if (i < 3 && ov[0]) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin failures++; $display("FAIL midreset_valid: got early valid expected none"); end
    drain(0, 0, 4, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_m[i] !== mdl_m[i] || cap_e[i] !== mdl_e) begin
        failures++;
        $display("FAIL midreset_elem[%0d]: got m=%0d e=%0d expected m=%0d e=%0d", i, cap_m[i], cap_e[i], mdl_m[i], mdl_e);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) res[k] = '0;
    test_reset();
    test_basic();
    test_underflow();
    test_saturate();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midblock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
